// File: rtl/dds_voice_mixer_pkg.sv
// Shared constants and types for the time-multiplexed DDS voice mixer.
package tone_gen_pkg;

  localparam logic [1:0] FLD_INCR = 2'd0;
  localparam logic [1:0] FLD_VOL  = 2'd1;
  localparam logic [1:0] FLD_CTRL = 2'd2;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_t;

  localparam int CTRL_EN  = 2;
  localparam int CTRL_CLR = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_WAVE,
    ST_DCA,
    ST_MIX,
    ST_DONE
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/dds_voice_mixer_if.sv
// Register-write, sample-tick and sample-output signals of the voice mixer.
interface dds_voice_mixer_if #(
  parameter int PHASE_W  = 16,
  parameter int VOICE_AW = 3
);
  logic                sample_tick_in;
  logic [VOICE_AW+1:0] addr_in;
  logic [PHASE_W-1:0]  data_in;
  logic                data_valid_in;
  logic [15:0]         data_out;
  logic                data_valid_out;
  logic                overrun_out;
  logic                busy_out;

  modport master (
    output sample_tick_in, addr_in, data_in, data_valid_in,
    input  data_out, data_valid_out, overrun_out, busy_out
  );

  modport slave (
    input  sample_tick_in, addr_in, data_in, data_valid_in,
    output data_out, data_valid_out, overrun_out, busy_out
  );
endinterface

// File: rtl/dds_voice_mixer_wave_gen.sv
// Combinational waveform shaper: maps the top 16 phase bits to a signed sample.
module dds_wave_gen
  import tone_gen_pkg::*;
(
  input  logic [15:0]        p,
  input  wave_t              wave_sel,
  input  logic [15:0]        lfsr,
  output logic signed [15:0] wave
);
  logic [15:0] fold;

  always_comb begin
    fold = p[15] ? ~p : p;
    wave = '0;
    case (wave_sel)
      WAVE_SQUARE: wave = p[15] ? SAT_MIN : SAT_MAX;
      WAVE_SAW:    wave = p ^ 16'h8000;
      WAVE_TRI:    wave = 16'(fold << 1) ^ 16'h8000;
      WAVE_NOISE:  wave = lfsr;
      default:     wave = '0;
    endcase
  end
endmodule

// File: rtl/dds_voice_mixer.sv
// Time-multiplexed DDS mixer: four clock slots per voice, one saturated sample per tick.
module dds_voice_mixer
  import tone_gen_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 16,
  localparam int VOICE_AW  = $clog2(NUM_VOICES)
) (
  input logic              clk_in,
  input logic              reset_in,
  dds_voice_mixer_if.slave bus
);
  localparam int ACC_W = 16 + VOICE_AW;

  state_t                   state, state_nxt;
  logic [VOICE_AW-1:0]      voice;
  logic [PHASE_W-1:0]       phase [NUM_VOICES];
  logic [PHASE_W-1:0]       incr  [NUM_VOICES];
  logic [7:0]               vol   [NUM_VOICES];
  wave_t                    wsel  [NUM_VOICES];
  logic [NUM_VOICES-1:0]    en;
  logic [NUM_VOICES-1:0]    clr_vec;
  logic signed [15:0]       wave_q, scaled_q, wave_c;
  logic signed [24:0]       prod;
  logic signed [ACC_W-1:0]  acc;
  logic [15:0]              lfsr;
  logic [15:0]              sat_val;
  logic [15:0]              sample_q;
  logic                     valid_q, overrun_q;
  logic                     busy, frame_start;
  logic [1:0]               wr_field;
  logic [VOICE_AW-1:0]      wr_voice;

  assign wr_field = bus.addr_in[VOICE_AW+1:VOICE_AW];
  assign wr_voice = bus.addr_in[VOICE_AW-1:0];

  assign busy        = (state != ST_IDLE) || valid_q;
  assign frame_start = (state == ST_IDLE) && bus.sample_tick_in && !busy;

  dds_wave_gen u_wave (
    .p        (phase[voice][PHASE_W-1 -: 16]),
    .wave_sel (wsel[voice]),
    .lfsr     (lfsr),
    .wave     (wave_c)
  );

  always_comb begin
    prod = wave_q * $signed({1'b0, vol[voice]});
    if (&acc[ACC_W-1:15] || ~|acc[ACC_W-1:15]) sat_val = acc[15:0];
    else sat_val = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
    for (int unsigned i = 0; i < NUM_VOICES; i++)
      clr_vec[i] = bus.data_valid_in && (wr_field == FLD_CTRL) &&
                   (wr_voice == VOICE_AW'(i)) && bus.data_in[CTRL_CLR];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (frame_start) state_nxt = ST_ACC;
      ST_ACC:  state_nxt = ST_WAVE;
      ST_WAVE: state_nxt = ST_DCA;
      ST_DCA:  state_nxt = ST_MIX;
      ST_MIX:  state_nxt = (voice == VOICE_AW'(NUM_VOICES - 1)) ? ST_DONE : ST_ACC;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state     <= ST_IDLE;
      voice     <= '0;
      wave_q    <= '0;
      scaled_q  <= '0;
      acc       <= '0;
      lfsr      <= LFSR_SEED;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      en        <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        incr[i]  <= '0;
        vol[i]   <= '0;
        wsel[i]  <= WAVE_SQUARE;
      end
    end else begin
      state     <= state_nxt;
      valid_q   <= (state == ST_DONE);
      overrun_q <= bus.sample_tick_in && busy;

      if (bus.data_valid_in) begin
        case (wr_field)
          FLD_INCR: incr[wr_voice] <= bus.data_in;
          FLD_VOL:  vol[wr_voice]  <= bus.data_in[7:0];
          FLD_CTRL: begin
            wsel[wr_voice] <= wave_t'(bus.data_in[1:0]);
            en[wr_voice]   <= bus.data_in[CTRL_EN];
          end
          default: ;
        endcase
      end

      // A phase_clear landing on the same edge as this voice's ACC step takes priority.
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (clr_vec[i]) phase[i] <= '0;
        else if (state == ST_ACC && voice == VOICE_AW'(i) && en[i])
          phase[i] <= phase[i] + incr[i];
      end

      if (frame_start) begin
        voice <= '0;
        acc   <= '0;
      end

      case (state)
        ST_WAVE: wave_q   <= wave_c;
        ST_DCA:  scaled_q <= en[voice] ? 16'(prod >>> 8) : 16'sd0;
        ST_MIX: begin
          acc   <= acc + ACC_W'(scaled_q);
          voice <= voice + 1'b1;
        end
        ST_DONE: begin
          sample_q <= sat_val;
          lfsr     <= lfsr_next(lfsr);
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out       = sample_q;
  assign bus.data_valid_out = valid_q;
  assign bus.overrun_out    = overrun_q;
  assign bus.busy_out       = busy;
endmodule

// File: tb/tb_dds_voice_mixer.sv
// Scoreboard bench for dds_voice_mixer: expected samples queued at each tick, popped on data_valid_out.
module tb_dds_voice_mixer;
  import tone_gen_pkg::*;

  localparam int N  = 8;
  localparam int PW = 16;
  localparam int AW = 3;

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  dds_voice_mixer_if #(.PHASE_W(PW), .VOICE_AW(AW)) bus ();

  dds_voice_mixer #(.NUM_VOICES(N), .PHASE_W(PW)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (bus.data_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got data_out %0h with no frame pending", bus.data_out);
      end else begin
        check("data_out", {16'h0, bus.data_out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wr(input logic [1:0] field, input int voice, input logic [PW-1:0] data);
    @(negedge clk_in);
    bus.addr_in       = {field, AW'(voice)};
    bus.data_in       = data;
    bus.data_valid_in = 1'b1;
    @(negedge clk_in);
    bus.data_valid_in = 1'b0;
  endtask

  task automatic wr_all(input logic [1:0] field, input logic [PW-1:0] data);
    for (int v = 0; v < N; v++) wr(field, v, data);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  // extra_tick >= 0 re-ticks that many cycles into the frame; clr0 writes
  // clear|enable|saw to voice 0 so it commits on voice 0's ACC edge.
  task automatic run_frame(input logic [15:0] exp, input int extra_tick, input bit clr0);
    int busy_n, valid_at, nvalid, ov;
    bit done;
    busy_n = 0; valid_at = -1; nvalid = 0; ov = 0; done = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk_in);
    bus.sample_tick_in = 1'b1;
    @(negedge clk_in);
    bus.sample_tick_in = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (clr0 && n == 0) begin
        bus.addr_in       = {FLD_CTRL, AW'(0)};
        bus.data_in       = PW'(16'h000D);
        bus.data_valid_in = 1'b1;
      end else begin
        bus.data_valid_in = 1'b0;
      end
      bus.sample_tick_in = (n == extra_tick);
      if (bus.busy_out) busy_n++;
      if (bus.data_valid_out) begin
        nvalid++;
        valid_at = n;
      end
      if (bus.overrun_out) ov++;
      if (n > 0 && !bus.busy_out) done = 1'b1;
      else @(negedge clk_in);
    end
    bus.sample_tick_in = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: busy_out still %0b after 200 cycles, required 0", bus.busy_out);
    end
    check("busy_cycles", busy_n, 34);
    check("valid_cycle", valid_at, 33);
    check("valid_pulses", nvalid, 1);
    check("overrun_pulses", ov, (extra_tick >= 0) ? 1 : 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data_out"}, {16'h0, bus.data_out}, 32'h0);
    check({tag, "_valid"}, {31'h0, bus.data_valid_out}, 32'h0);
    check({tag, "_overrun"}, {31'h0, bus.overrun_out}, 32'h0);
    check({tag, "_busy"}, {31'h0, bus.busy_out}, 32'h0);
  endtask

  initial begin
    reset_in           = 1'b1;
    bus.sample_tick_in = 1'b1;
    bus.addr_in        = '0;
    bus.data_in        = '0;
    bus.data_valid_in  = 1'b0;
    @(negedge clk_in);
    bus.sample_tick_in = 1'b0;
    @(negedge clk_in);
    check_idle_outputs("reset");
    reset_in = 1'b0;
    @(negedge clk_in);
    check("tick_with_reset_busy", {31'h0, bus.busy_out}, 32'h0);

    // all voices disabled
    run_frame(16'h0000, -1, 1'b0);

    // voice 0 square, full volume, phase walks 0x1000 per frame
    wr(FLD_INCR, 0, 16'h1000);
    wr(FLD_VOL, 0, 16'h00FF);
    wr(FLD_CTRL, 0, 16'h0004);
    for (int f = 1; f <= 7; f++) run_frame(16'h7F7F, -1, 1'b0);
    run_frame(16'h8080, -1, 1'b0);

    // eight voices at full square: positive and negative saturation, then in-range sum
    do_reset();
    wr_all(FLD_INCR, 16'h0000);
    wr_all(FLD_VOL, 16'h00FF);
    wr_all(FLD_CTRL, 16'h0004);
    run_frame(16'h7FFF, -1, 1'b0);
    wr_all(FLD_VOL, 16'h0020);
    run_frame(16'h7FF8, -1, 1'b0);
    wr_all(FLD_VOL, 16'h00FF);
    wr_all(FLD_INCR, 16'h8000);
    run_frame(16'h8000, -1, 1'b0);

    // overrun: second tick 5 cycles into the frame
    do_reset();
    wr(FLD_INCR, 0, 16'h1000);
    wr(FLD_VOL, 0, 16'h00FF);
    wr(FLD_CTRL, 0, 16'h0004);
    run_frame(16'h7F7F, 5, 1'b0);

    // saw with phase_clear, then clear colliding with ACC on the same edge
    do_reset();
    wr(FLD_INCR, 0, 16'h0100);
    wr(FLD_VOL, 0, 16'h00FF);
    wr(FLD_CTRL, 0, 16'h0005);
    run_frame(16'h817F, -1, 1'b0);
    run_frame(16'h827E, -1, 1'b0);
    run_frame(16'h837D, -1, 1'b0);
    wr(FLD_CTRL, 0, 16'h000D);
    run_frame(16'h817F, -1, 1'b0);
    run_frame(16'h8080, -1, 1'b1);
    run_frame(16'h817F, -1, 1'b0);

    // reset 10 cycles into a frame aborts it
    @(negedge clk_in);
    bus.sample_tick_in = 1'b1;
    @(negedge clk_in);
    bus.sample_tick_in = 1'b0;
    repeat (10) @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    check_idle_outputs("midframe_reset");
    reset_in = 1'b0;
    repeat (40) @(negedge clk_in);
    check("midframe_reset_busy_after", {31'h0, bus.busy_out}, 32'h0);
    run_frame(16'h0000, -1, 1'b0);

    // noise from the seeded LFSR, then its first successor 0xE270
    do_reset();
    wr(FLD_VOL, 0, 16'h00FF);
    wr(FLD_CTRL, 0, 16'h0007);
    run_frame(16'hAD34, -1, 1'b0);
    run_frame(16'hE28D, -1, 1'b0);

    // triangle at quarter-cycle steps
    do_reset();
    wr(FLD_INCR, 0, 16'h4000);
    wr(FLD_VOL, 0, 16'h00FF);
    wr(FLD_CTRL, 0, 16'h0006);
    run_frame(16'h0000, -1, 1'b0);
    run_frame(16'h7F7E, -1, 1'b0);
    run_frame(16'hFFFE, -1, 1'b0);

    repeat (5) @(negedge clk_in);
    check("frames_left_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
